// File: rtl/softmax_exp_ctrl_16.sv
// softmax_exp_ctrl_16
// Sequencer for the 16-bit softmax exponent stage.
//
// Flow:
//   1. start_i streams N max-subtracted operands from the source buffer into
//      the exp unit, with a downscale-done pulse on the last operand.
//   2. Each returned exponent is written to the destination buffer.
//   3. The returned exponents are accumulated into sum_o for the divider.
//
// Ports:
//   clock_i, reset_n_i            clock, async active-low reset
//   start_i, vec_len_i            start pulse and element count (0..2^addr_width)
//   busy_o, done_o, error_o       status (done_o one-cycle pulse, error_o sticky)
//   src_rd_en_o/addr_o/data_i     source buffer read port (1-cycle read latency)
//   exp_data_o/valid_o            operand stream to the exp unit
//   exp_downscale_done_o          pulse with the last operand
//   exp_data_i/valid_i            exp results
//   dst_wr_en_o/addr_o/data_o     destination buffer write port
//   sum_o                         running sum of accepted exp results
//
// Optional feature:
//   SOFTMAX_EXP_CTRL_TIMEOUT_EN   enables the DRAIN watchdog. On expiry the
//                                 block ends the vector with error_o set and
//                                 sum_o holding the partial sum. When the
//                                 macro is undefined, error_o is tied low and
//                                 DRAIN waits indefinitely.
module softmax_exp_ctrl_16 #(
    parameter int data_size      = 16,
    parameter int addr_width     = 6,
    parameter int timeout_cycles = 32
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic                           start_i,
    input  logic [addr_width:0]            vec_len_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic                           src_rd_en_o,
    output logic [addr_width-1:0]          src_rd_addr_o,
    input  logic [data_size-1:0]           src_rd_data_i,
    output logic [data_size-1:0]           exp_data_o,
    output logic                           exp_data_valid_o,
    output logic                           exp_downscale_done_o,
    input  logic [data_size-1:0]           exp_data_i,
    input  logic                           exp_data_valid_i,
    output logic                           dst_wr_en_o,
    output logic [addr_width-1:0]          dst_wr_addr_o,
    output logic [data_size-1:0]           dst_wr_data_o,
    output logic [data_size+addr_width-1:0] sum_o
);
    localparam int CW = addr_width + 1;
    localparam int SW = data_size + addr_width;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         iss_q, iss_d;
    logic [CW-1:0]         ret_q, ret_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [1:0]            vld_q, vld_d;    // read strobe delayed: [0] data at RAM out, [1] operand reg
    logic [1:0]            last_q, last_d;  // same pipe for the last-element marker
    logic [data_size-1:0]  opnd_q, opnd_d;
    logic                  wr_en_q, wr_en_d;
    logic [addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [data_size-1:0]  wr_data_q, wr_data_d;

    logic rd_en, rd_last, accept;

`ifdef SOFTMAX_EXP_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(timeout_cycles + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        iss_d     = iss_q;
        ret_d     = ret_q;
        sum_d     = sum_q;
        opnd_d    = src_rd_data_i;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        rd_en   = (state_q == S_ISSUE);
        rd_last = rd_en && (iss_q == len_q - CW'(1));
        vld_d   = {vld_q[0], rd_en};
        last_d  = {last_q[0], rd_last};

        // Results are only taken while a vector is in flight and still owed;
        // anything else from the exp unit is dropped.
        accept = exp_data_valid_i && (state_q == S_ISSUE || state_q == S_DRAIN)
                 && (ret_q != len_q);
        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ret_q[addr_width-1:0];
            wr_data_d = exp_data_i;
            sum_d     = sum_q + SW'(exp_data_i);
            ret_d     = ret_q + CW'(1);
        end

`ifdef SOFTMAX_EXP_CTRL_TIMEOUT_EN
        wd_d  = '0;
        err_d = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = vec_len_i;
                    iss_d   = '0;
                    ret_d   = '0;
                    sum_d   = '0;
`ifdef SOFTMAX_EXP_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = (vec_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                iss_d = iss_q + CW'(1);
                if (rd_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // ret_q reaches N on the same edge that registers the last write
                if (ret_q == len_q) begin
                    state_d = S_DONE;
                end
`ifdef SOFTMAX_EXP_CTRL_TIMEOUT_EN
                else begin
                    wd_d = exp_data_valid_i ? '0 : wd_q + WW'(1);
                    if (wd_d == WW'(timeout_cycles)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            iss_q     <= '0;
            ret_q     <= '0;
            sum_q     <= '0;
            vld_q     <= '0;
            last_q    <= '0;
            opnd_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            iss_q     <= iss_d;
            ret_q     <= ret_d;
            sum_q     <= sum_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            opnd_q    <= opnd_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef SOFTMAX_EXP_CTRL_TIMEOUT_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    assign busy_o               = (state_q != S_IDLE);
    assign done_o               = (state_q == S_DONE);
    assign src_rd_en_o          = rd_en;
    assign src_rd_addr_o        = iss_q[addr_width-1:0];
    assign exp_data_o           = opnd_q;
    assign exp_data_valid_o     = vld_q[1];
    assign exp_downscale_done_o = last_q[1];
    assign dst_wr_en_o          = wr_en_q;
    assign dst_wr_addr_o        = wr_addr_q;
    assign dst_wr_data_o        = wr_data_q;
    assign sum_o                = sum_q;

endmodule
